ctrl_pipe_unit: RTL

Registered decode/control stage for the RV32I core. It decodes the instruction into the standard control fields and holds them, with PC and instruction, in an ID/EX output register. Valid/ready handshakes sit on both sides. It adds load-use hazard stalling, flush on redirect, illegal-opcode flagging and an optional multi-cycle MUL/DIV issue stall.

---
 rtl/ctrl_pipe_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - RV32I decode/control stage with ID/EX register, load-use stall, flush
// Optional macro CTRL_MULDIV_EN: RV32M decode plus a MULDIV_LAT-cycle issue stall.
module ctrl_pipe_unit #(
  parameter int XLEN       = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rd,
  output logic [1:0]      out_rs1Sel,
  output logic [1:0]      out_rs2Sel,
  output logic [1:0]      out_wbSel,
  output logic            out_brOrJmp,
  output logic            out_useJalr,
  output logic            out_isBranch,
  output logic [2:0]      out_func3,
  output logic            out_func1,
  output logic            out_regWrite,
  output logic            out_memRead,
  output logic            out_memWrite,
  output logic [2:0]      out_funcMem,
  output logic            out_illegal,
  output logic            out_muldiv,
  output logic            hazard_stall
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [1:0]      rs1sel;
    logic [1:0]      rs2sel;
    logic [1:0]      wbsel;
    logic            brorjmp;
    logic            usejalr;
    logic            isbranch;
    logic [2:0]      func3;
    logic            func1;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [2:0]      funcmem;
    logic            illegal;
    logic            muldiv;
  } ctrl_t;

  ctrl_t d, q;
  logic  uses_rs1, uses_rs2;
  logic  hazard, busy, accept;
  logic  [2:0] f3;

  assign f3 = in_instr[14:12];

  always_comb begin
    d          = '0;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    d.pc       = in_pc;
    d.instr    = in_instr;
    case (in_instr[6:0])
      OPC_LUI:   begin d.wbsel = 2'b11; d.regwrite = 1'b1; end
      OPC_AUIPC: begin d.wbsel = 2'b01; d.regwrite = 1'b1; end
      OPC_JAL:   begin d.regwrite = 1'b1; d.brorjmp = 1'b1; end
      OPC_JALR: begin
        d.rs1sel = 2'b01; d.rs2sel = 2'b10; d.regwrite = 1'b1; d.usejalr = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        d.isbranch = 1'b1; d.func3 = f3;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        d.rs1sel = 2'b01; d.rs2sel = 2'b01; d.memwrite = 1'b1; d.funcmem = f3;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        d.rs1sel = 2'b01; d.rs2sel = 2'b10; d.wbsel = 2'b10; d.regwrite = 1'b1;
        d.memread = 1'b1; d.funcmem = f3;
        uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        d.rs1sel = 2'b01; d.rs2sel = 2'b11; d.wbsel = 2'b01; d.regwrite = 1'b1;
        d.func3 = f3; d.func1 = in_instr[30];
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
`ifdef CTRL_MULDIV_EN
        if (in_instr[31:25] == 7'b0000001) begin
          d.muldiv = 1'b1;
          d.func1  = 1'b0;
        end
`endif
      end
      OPC_OPIMM: begin
        // only the shift-right immediates carry a real funct7 bit
        d.rs1sel = 2'b01; d.rs2sel = 2'b10; d.wbsel = 2'b01; d.regwrite = 1'b1;
        d.func3 = f3; d.func1 = (f3 == 3'b101) ? in_instr[30] : 1'b0;
        uses_rs1 = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.rd = d.regwrite ? in_instr[11:7] : 5'd0;
  end

  assign hazard = out_valid && q.memread && (q.rd != 5'd0) && in_valid &&
                  ((uses_rs1 && in_instr[19:15] == q.rd) ||
                   (uses_rs2 && in_instr[24:20] == q.rd));
  assign hazard_stall = hazard;
  assign in_ready     = flush || ((!out_valid || out_ready) && !hazard && !busy);
  assign accept       = in_valid && in_ready && !flush;

`ifdef CTRL_MULDIV_EN
  logic [3:0] md_cnt;
  assign busy = (md_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= 4'd0;
    end else if (flush) begin
      md_cnt <= 4'd0;
    end else if (out_valid && out_ready && q.muldiv) begin
      md_cnt <= 4'(MULDIV_LAT);
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end
`else
  logic [9:0] unused_bits;
  assign unused_bits = {4'(MULDIV_LAT), in_instr[31], in_instr[29:25]};
  assign busy        = 1'b0;
`endif

  // a non-accepting cycle with a free output slot loads an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= d;
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
      q         <= '0;
    end
  end

  assign out_pc       = q.pc;
  assign out_instr    = q.instr;
  assign out_rd       = q.rd;
  assign out_rs1Sel   = q.rs1sel;
  assign out_rs2Sel   = q.rs2sel;
  assign out_wbSel    = q.wbsel;
  assign out_brOrJmp  = q.brorjmp;
  assign out_useJalr  = q.usejalr;
  assign out_isBranch = q.isbranch;
  assign out_func3    = q.func3;
  assign out_func1    = q.func1;
  assign out_regWrite = q.regwrite;
  assign out_memRead  = q.memread;
  assign out_memWrite = q.memwrite;
  assign out_funcMem  = q.funcmem;
  assign out_illegal  = q.illegal;
  assign out_muldiv   = q.muldiv;

endmodule
